// File: rtl/led_gpio_access_arbiter.sv
// rtl/led_gpio_access_arbiter.sv - round-robin arbiter sharing the LED GPIO slave over Avalon-MM
module led_gpio_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [2*NUM_REQ-1:0]        req_op,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [DATA_W-1:0]           shadow_out,
  output logic                        busy,
  output logic [2:0]                  avm_address,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [31:0]                 avm_writedata,
  input  logic [31:0]                 avm_readdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_ACK,
    S_GAP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   data_q;
  logic [3:0]          gap_cnt;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;

  logic [1:0]          op_arr   [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  logic                unused_readdata;
  assign unused_readdata = ^avm_readdata[31:DATA_W];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]   = req_op[2*g +: 2];
    assign data_arr[g] = req_data[DATA_W*g +: DATA_W];
  end

  // Round-robin pick: first pending request after the last granted index, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic for the single in-flight access
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (win_found) state_next = S_ISSUE;
      S_ISSUE: state_next = (op_q == OP_READ) ? S_CAPT : S_ACK;
      S_CAPT:  state_next = S_ACK;
      S_ACK:   state_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == GAP_LAST) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered datapath and bus outputs, timed so each lines up with its state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant     <= LAST_IDX;
      grant_idx      <= '0;
      op_q           <= OP_WRITE;
      data_q         <= '0;
      gap_cnt        <= '0;
      ack            <= '0;
      rdata          <= '0;
      shadow_out     <= '0;
      busy           <= 1'b0;
      avm_address    <= ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      ack  <= '0;
      busy <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_idx      <= win_idx;
            last_grant     <= win_idx;
            op_q           <= op_arr[win_idx];
            data_q         <= data_arr[win_idx];
            avm_chipselect <= 1'b1;
            avm_write_n    <= (op_arr[win_idx] == OP_READ);
            avm_writedata  <= 32'(data_arr[win_idx]);
            case (op_arr[win_idx])
              OP_SET:   avm_address <= ADDR_SET;
              OP_CLEAR: avm_address <= ADDR_CLR;
              default:  avm_address <= ADDR_DATA;
            endcase
          end
        end
        S_ISSUE: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          case (op_q)
            OP_WRITE: shadow_out <= data_q;
            OP_SET:   shadow_out <= shadow_out | data_q;
            OP_CLEAR: shadow_out <= shadow_out & ~data_q;
            default:  shadow_out <= shadow_out;
          endcase
          if (op_q != OP_READ) ack[grant_idx] <= 1'b1;
        end
        S_CAPT: begin
          rdata          <= avm_readdata[DATA_W-1:0];
          ack[grant_idx] <= 1'b1;
        end
        S_ACK: begin
          gap_cnt <= '0;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
